// File: rtl/fancytimer_cmd_pkg.sv
// Shared types and constants for the fancy-timer command block.
// The optional measurement feature is selected with FANCYTIMER_CMD_CHECK_EN.
package fancytimer_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2,
      ACK       = 2'd3
   } state_t;

   localparam logic [3:0] PREAMBLE   = 4'b1101;
   localparam int         FRAME_BITS = 8;

   // Frame as it appears on the serial line, MSB first.
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0] d);
      return {PREAMBLE, d};
   endfunction

endpackage

// File: rtl/fancytimer_cmd_ser.sv
// Load/shift register feeding the timer's serial data line, with a bit counter.
// Zeros shift in behind the frame, so the line idles low once the frame is out.
module fancytimer_cmd_ser
   import fancytimer_cmd_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic [FRAME_BITS-1:0] i_frame,
   input  logic                  i_shift,
   output logic                  o_ser,
   output logic                  o_last
);

   localparam int CW = $clog2(FRAME_BITS);

   logic [FRAME_BITS-1:0] r_sh;
   logic [CW-1:0]         r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_sh  <= i_frame;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_sh  <= {r_sh[FRAME_BITS-2:0], 1'b0};
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_ser  = r_sh[FRAME_BITS-1];
   assign o_last = (r_cnt == CW'(FRAME_BITS - 1));

endmodule

// File: rtl/fancytimer_cmd.sv
// Command-side driver for the serial-programmed fancy timer: sends the delay frame,
// waits for done, acks it and reports the measured duration (FANCYTIMER_CMD_CHECK_EN).
module fancytimer_cmd
   import fancytimer_cmd_pkg::*;
#(
   parameter int PERIOD  = 1000,
   parameter int CNT_W   = 14,
   parameter int TIMEOUT = 20000,
   parameter int TO_W    = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       delay,
   output logic             ready,
   output logic             data,
   input  logic             counting,
   input  logic             done,
   output logic             ack,
   output logic             result_valid,
   output logic             result_ok,
   output logic             result_timeout,
   output logic [CNT_W-1:0] measured,
   output state_t           dbg_state
);

   // Handshake: a request transfers on a rising edge where start && ready;
   // ready is high only in IDLE, so start while busy has no effect.

   state_t          r_state, w_next;
   logic            r_ack, r_rv, r_ok, r_to;
   logic [TO_W-1:0] r_to_cnt;
   logic            w_accept, w_shift, w_last, w_to_hit, w_match;

   fancytimer_cmd_ser u_ser (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_accept),
      .i_frame (make_frame(delay)),
      .i_shift (w_shift),
      .o_ser   (data),
      .o_last  (w_last)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (start)         w_next = SEND;
         SEND:      if (w_last)        w_next = WAIT_DONE;
         WAIT_DONE: if (done)          w_next = ACK;
                    else if (w_to_hit) w_next = IDLE;
         ACK:                          w_next = IDLE;
         default:                      w_next = IDLE;
      endcase
   end

   always_comb begin
      ready    = (r_state == IDLE);
      w_accept = (r_state == IDLE) && start;
      w_shift  = (r_state == SEND);
      w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));
   end

   // Done sampled on the same edge as timeout expiry takes the done path.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack    <= 1'b0;
         r_rv     <= 1'b0;
         r_ok     <= 1'b0;
         r_to     <= 1'b0;
         r_to_cnt <= '0;
      end else begin
         r_ack <= (r_state == WAIT_DONE) && done;
         r_rv  <= 1'b0;
         if (w_accept) begin
            r_ok     <= 1'b0;
            r_to     <= 1'b0;
            r_to_cnt <= '0;
         end else if (r_state == WAIT_DONE) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (!done && w_to_hit) begin
               r_rv <= 1'b1;
               r_to <= 1'b1;
               r_ok <= 1'b0;
            end
         end else if (r_state == ACK) begin
            r_rv <= 1'b1;
            r_to <= 1'b0;
            r_ok <= w_match;
         end
      end
   end

`ifdef FANCYTIMER_CMD_CHECK_EN
   logic [3:0]       r_delay;
   logic [CNT_W-1:0] r_meas;
   logic [CNT_W-1:0] w_expected;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_delay <= '0;
         r_meas  <= '0;
      end else if (w_accept) begin
         r_delay <= delay;
         r_meas  <= '0;
      end else if ((r_state == WAIT_DONE) && counting && (r_meas != '1)) begin
         r_meas <= r_meas + CNT_W'(1);
      end
   end

   assign w_expected = CNT_W'((32'(r_delay) + 32'd1) * 32'(PERIOD));
   assign w_match    = (r_meas == w_expected);
   assign measured   = r_meas;
`else
   logic w_unused_inputs;
   assign w_unused_inputs = counting;
   assign w_match         = 1'b1;
   assign measured        = '0;
`endif

   assign ack            = r_ack;
   assign result_valid   = r_rv;
   assign result_ok      = r_ok;
   assign result_timeout = r_to;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_fancytimer_cmd.sv
// Randomized bench for fancytimer_cmd with a behavioural timer model and result scoreboard.
// Expectations follow FANCYTIMER_CMD_CHECK_EN the same way the design build does.
module tb_fancytimer_cmd;
   import fancytimer_cmd_pkg::*;

   localparam int P_PERIOD  = 20;
   localparam int P_CNT_W   = 9;
   localparam int P_TIMEOUT = 400;
   localparam int P_TO_W    = 9;
`ifdef FANCYTIMER_CMD_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset, start, counting, done;
   logic [3:0]         delay;
   logic               ready, data, ack, result_valid, result_ok, result_timeout;
   logic [P_CNT_W-1:0] measured;
   state_t             dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int ack_cnt  = 0;
   int rv_cnt   = 0;
   logic [P_CNT_W+1:0] exp_q[$];

   fancytimer_cmd #(
      .PERIOD (P_PERIOD), .CNT_W (P_CNT_W), .TIMEOUT (P_TIMEOUT), .TO_W (P_TO_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .delay          (delay),
      .ready          (ready),
      .data           (data),
      .counting       (counting),
      .done           (done),
      .ack            (ack),
      .result_valid   (result_valid),
      .result_ok      (result_ok),
      .result_timeout (result_timeout),
      .measured       (measured),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   always @(negedge clk) begin
      if (ack === 1'b1)          ack_cnt++;
      if (result_valid === 1'b1) rv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One transaction. Called at a negedge with the DUT idle. The timer model decodes
   // the frame from the line and counts (code+1)*PERIOD+adj cycles; without done it
   // counts adj cycles and never finishes.
   task automatic run_txn(input logic [3:0] d, input int adj, input bit give_done,
                          input bit hold);
      logic [7:0]         rx;
      logic [P_CNT_W+1:0] e;
      int n_exp, n, c, ack0, rv0;
      check("ready_idle", ready, 1);
      ack0 = ack_cnt;
      rv0  = rv_cnt;
      n_exp = give_done ? (int'(d) + 1) * P_PERIOD + adj : adj;
      exp_q.push_back({!give_done,
                       give_done && (!CHECK_EN || adj == 0),
                       CHECK_EN ? P_CNT_W'(n_exp) : P_CNT_W'(0)});
      start = 1'b1;
      delay = d;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      rx = '0;
      for (int k = 0; k < 8; k++) begin
         delay = 4'($urandom_range(0, 15));
         @(negedge clk);
         rx = {rx[6:0], data};
      end
      check("frame", rx, make_frame(d));
      @(posedge clk);
      @(negedge clk);
      check("line_idle", data, 0);
      check("busy", ready, 0);
      n = give_done ? (int'(rx[3:0]) + 1) * P_PERIOD + adj : adj;
      if (n > 0) begin
         counting = 1'b1;
         repeat (n) @(posedge clk);
         @(negedge clk);
         counting = 1'b0;
      end
      c = n;
      if (give_done) begin
         done = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("ack_high", ack, 1);
         check("rv_early", result_valid, 0);
         @(posedge clk);
         @(negedge clk);
         done = 1'b0;
         check("ack_low", ack, 0);
      end else begin
         while (result_valid !== 1'b1 && c < P_TIMEOUT + 8) begin
            @(posedge clk);
            c++;
            @(negedge clk);
         end
         check("timeout_cycles", c, P_TIMEOUT);
      end
      e = exp_q.pop_front();
      check("result_valid", result_valid, 1);
      check("result_timeout", result_timeout, e[P_CNT_W+1]);
      check("result_ok", result_ok, e[P_CNT_W]);
      check("measured", measured, e[P_CNT_W-1:0]);
      check("ready_after", ready, 1);
      #1;
      check("ack_pulses", ack_cnt - ack0, give_done ? 1 : 0);
      check("rv_pulses", rv_cnt - rv0, 1);
   endtask

   task automatic reset_during_send(input logic [3:0] d);
      int rv0;
      rv0   = rv_cnt;
      start = 1'b1;
      delay = d;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_send_busy", ready, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_data", data, 0);
      check("rst_ready", ready, 1);
      check("rst_rv", result_valid, 0);
      check("rst_measured", measured, 0);
      repeat (3) @(negedge clk);
      #1;
      check("rst_no_result", rv_cnt - rv0, 0);
   endtask

   initial begin
      int m, d, adj;
      reset    = 1'b1;
      start    = 1'b0;
      delay    = '0;
      counting = 1'b0;
      done     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_ready", ready, 1);
      check("reset_data", data, 0);
      check("reset_ack", ack, 0);
      check("reset_rv", result_valid, 0);
      check("reset_ok", result_ok, 0);
      check("reset_timeout", result_timeout, 0);
      check("reset_measured", measured, 0);
      check("reset_state", 32'(dbg_state), 32'(IDLE));

      run_txn(4'h1, 0, 1'b1, 1'b0);
      run_txn(4'hE, 0, 1'b1, 1'b0);
      run_txn(4'h3, 0, 1'b0, 1'b0);
      run_txn(4'h1, -1, 1'b1, 1'b0);
      reset_during_send(4'h9);
      run_txn(4'h0, 0, 1'b1, 1'b0);
      run_txn(4'h5, 0, 1'b1, 1'b1);
      run_txn(4'h9, 0, 1'b1, 1'b0);
      run_txn(4'hF, P_TIMEOUT - 1 - 16 * P_PERIOD, 1'b1, 1'b0);

      repeat (12) begin
         d = $urandom_range(0, 15);
         m = $urandom_range(0, 2);
         case (m)
            0: run_txn(4'(d), 0, 1'b1, 1'b0);
            1: begin
               adj = $urandom_range(1, 5);
               if ($urandom_range(0, 1) == 1) adj = -adj;
               run_txn(4'(d), adj, 1'b1, 1'b0);
            end
            default: run_txn(4'(d), $urandom_range(0, P_TIMEOUT - 1), 1'b0, 1'b0);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
